// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse on the open-drain data line
// with the response preamble and a 40-bit humidity/temperature/checksum frame.
module dht11_responder #(
    parameter int CLK_FREQ_HZ   = 25_000_000,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic       start_err
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int PW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    localparam logic [PW-1:0] PRESC_MAX    = PW'(CYC_PER_US - 1);
    localparam logic [15:0]   L_START_MIN  = 16'(START_MIN_US);
    localparam logic [15:0]   L_RESP_DELAY = 16'(RESP_DELAY_US);
    localparam logic [15:0]   L_RESP_LOW   = 16'(RESP_LOW_US);
    localparam logic [15:0]   L_RESP_HIGH  = 16'(RESP_HIGH_US);
    localparam logic [15:0]   L_BIT_LOW    = 16'(BIT_LOW_US);
    localparam logic [15:0]   L_BIT0       = 16'(BIT0_HIGH_US);
    localparam logic [15:0]   L_BIT1       = 16'(BIT1_HIGH_US);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   cnt;
    logic [5:0]    idx;
    logic [39:0]   frame;
    logic [1:0]    sync;
    logic [7:0]    csum;
    logic [15:0]   phase_len;
    logic          us_tick;
    logic          phase_end;
    logic          line;

    assign us_tick = (presc == PRESC_MAX);
    assign line    = sync[1];
    assign csum    = hum_int + hum_dec + temp_int + temp_dec;

    always_comb begin
        phase_len = L_BIT_LOW;
        case (state)
            RESP_WAIT: phase_len = L_RESP_DELAY;
            RESP_LOW:  phase_len = L_RESP_LOW;
            RESP_HIGH: phase_len = L_RESP_HIGH;
            BIT_HIGH:  phase_len = frame[idx] ? L_BIT1 : L_BIT0;
            default:   phase_len = L_BIT_LOW;
        endcase
    end

    assign phase_end = us_tick && (cnt == phase_len - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            cnt        <= '0;
            idx        <= '0;
            frame      <= '0;
            sync       <= 2'b11;
            dht_oe     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            start_err  <= 1'b0;
            // Our own drive (and its echo through the synchronizer) must not
            // look like a host start once we release the line.
            sync <= dht_oe ? 2'b11 : {sync[0], dht_in};

            presc <= us_tick ? '0 : presc + 1'b1;
            if (us_tick && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;

            // Every transition below also restarts the prescaler and phase counter.
            case (state)
                IDLE: begin
                    if (!line) begin
                        state <= HOST_LOW;
                        busy  <= 1'b1;
                        presc <= '0;
                        cnt   <= '0;
                    end
                end
                HOST_LOW: begin
                    if (line) begin
                        presc <= '0;
                        cnt   <= '0;
                        if (cnt >= L_START_MIN) begin
                            state <= RESP_WAIT;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            start_err <= 1'b1;
                        end
                    end
                end
                RESP_WAIT: begin
                    if (phase_end) begin
                        frame  <= {hum_int, hum_dec, temp_int, temp_dec, csum};
                        state  <= RESP_LOW;
                        dht_oe <= 1'b1;
                        presc  <= '0;
                        cnt    <= '0;
                    end
                end
                RESP_LOW: begin
                    if (phase_end) begin
                        state  <= RESP_HIGH;
                        dht_oe <= 1'b0;
                        presc  <= '0;
                        cnt    <= '0;
                    end
                end
                RESP_HIGH: begin
                    if (phase_end) begin
                        state  <= BIT_LOW;
                        idx    <= 6'd39;
                        dht_oe <= 1'b1;
                        presc  <= '0;
                        cnt    <= '0;
                    end
                end
                BIT_LOW: begin
                    if (phase_end) begin
                        state  <= BIT_HIGH;
                        dht_oe <= 1'b0;
                        presc  <= '0;
                        cnt    <= '0;
                    end
                end
                BIT_HIGH: begin
                    if (phase_end) begin
                        dht_oe <= 1'b1;
                        presc  <= '0;
                        cnt    <= '0;
                        if (idx == 6'd0) begin
                            state <= END_LOW;
                        end else begin
                            idx   <= idx - 6'd1;
                            state <= BIT_LOW;
                        end
                    end
                end
                END_LOW: begin
                    if (phase_end) begin
                        state      <= IDLE;
                        dht_oe     <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        presc      <= '0;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dht_oe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: 1 cycle per us, pull-up line model,
// frames decoded from the sensor drive and checked against hand-computed bytes.
`timescale 1ns/1ps
module tb_dht11_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_drive = 1'b0;
    logic       dht_in;
    logic       dht_oe;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
    logic       busy, frame_done, start_err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0, se_cnt = 0, oe_cnt = 0;

    assign dht_in = ~dht_oe & ~host_drive;

    dht11_responder #(
        .CLK_FREQ_HZ (1_000_000),
        .START_MIN_US(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dht_in    (dht_in),
        .dht_oe    (dht_oe),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .temp_int  (temp_int),
        .temp_dec  (temp_dec),
        .busy      (busy),
        .frame_done(frame_done),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (start_err)  se_cnt++;
        if (dht_oe)     oe_cnt++;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int          host_us;
        logic [7:0]  hi, hd, ti, td;
        logic [39:0] exp;
        logic        ok;
    } vec_t;

    vec_t tv[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic host_start(input int us, output logic busy_mid);
        busy_mid = 1'b0;
        @(negedge clk);
        host_drive = 1'b1;
        for (int i = 0; i < us; i++) begin
            @(negedge clk);
            if (i == 10) busy_mid = busy;
        end
        host_drive = 1'b0;
    endtask

    task automatic measure(input logic v, output int n);
        n = 0;
        while (dht_oe === v && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Decodes one frame from the sensor drive, starting at the host release.
    task automatic capture(output logic [39:0] bits, output int bad_t);
        int n;
        bits  = '0;
        bad_t = 0;
        n = 0;
        while (!dht_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_rng("resp_gap", n, 30, 34);
        check("busy_in_frame", {63'd0, busy}, 64'd1);
        measure(1'b1, n); if (n < 79 || n > 81) bad_t++;
        measure(1'b0, n); if (n < 79 || n > 81) bad_t++;
        for (int i = 39; i >= 0; i--) begin
            measure(1'b1, n);
            if (n < 49 || n > 51) bad_t++;
            measure(1'b0, n);
            bits[i] = (n > 48);
            if (bits[i] ? (n < 69 || n > 71) : (n < 25 || n > 27)) bad_t++;
        end
        measure(1'b1, n);
        if (n < 49 || n > 51) bad_t++;
    endtask

    initial begin
        logic [39:0] fr;
        int          bad, fd0, se0, oe0, se_at, r;
        logic        bm, prev;

        tv[0] = '{1200, 8'h37, 8'h00, 8'h18, 8'h00, 40'h37_00_18_00_4F, 1'b1};
        tv[1] = '{1200, 8'hFF, 8'hFF, 8'h01, 8'h02, 40'hFF_FF_01_02_01, 1'b1};
        tv[2] = '{1010, 8'h01, 8'h02, 8'h03, 8'h04, 40'h01_02_03_04_0A, 1'b1};
        tv[3] = '{1050, 8'h80, 8'h80, 8'h00, 8'h00, 40'h80_80_00_00_00, 1'b1};
        tv[4] = '{ 990, 8'hAA, 8'h55, 8'h00, 8'h00, 40'h0,              1'b0};
        tv[5] = '{1050, 8'h40, 8'h00, 8'h18, 8'h00, 40'h40_00_18_00_58, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_oe",   {63'd0, dht_oe},     64'd0);
        check("rst_busy", {63'd0, busy},       64'd0);
        check("rst_done", {63'd0, frame_done}, 64'd0);
        check("rst_serr", {63'd0, start_err},  64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            hum_int = tv[k].hi; hum_dec = tv[k].hd; temp_int = tv[k].ti; temp_dec = tv[k].td;
            fd0 = fd_cnt; se0 = se_cnt; oe0 = oe_cnt;
            host_start(tv[k].host_us, bm);
            check("busy_host_low", {63'd0, bm}, 64'd1);
            if (tv[k].ok) begin
                capture(fr, bad);
                check("frame", {24'd0, fr}, {24'd0, tv[k].exp});
                check_rng("bit_timing_errs", bad, 0, 0);
            end else begin
                repeat (20) @(negedge clk);
                check_rng("reject_oe_cycles", oe_cnt - oe0, 0, 0);
            end
            repeat (5) @(negedge clk);
            check_rng("frame_done_cnt", fd_cnt - fd0, tv[k].ok ? 1 : 0, tv[k].ok ? 1 : 0);
            check_rng("start_err_cnt",  se_cnt - se0, tv[k].ok ? 0 : 1, tv[k].ok ? 0 : 1);
            check("busy_after", {63'd0, busy}, 64'd0);
        end

        // Short host low: start_err a few cycles after release, line never driven.
        se0 = se_cnt; oe0 = oe_cnt; se_at = -1;
        host_start(500, bm);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (start_err && se_at < 0) se_at = c;
        end
        check_rng("start_err_delay", se_at, 2, 4);
        check_rng("start_err_pulses", se_cnt - se0, 1, 1);
        check_rng("short_oe_cycles", oe_cnt - oe0, 0, 0);
        check("short_busy", {63'd0, busy}, 64'd0);

        // hum_int changes during BIT_LOW of bit 35; the snapshot must be sent.
        hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h18; temp_dec = 8'h00;
        host_start(1050, bm);
        fork
            capture(fr, bad);
            begin
                r = 0; prev = 1'b0;
                for (int c = 0; c < 3000 && r < 6; c++) begin
                    @(negedge clk);
                    if (dht_oe && !prev) r++;
                    prev = dht_oe;
                end
                hum_int = 8'h40;
            end
        join
        check("snapshot_frame", {24'd0, fr}, {24'd0, 40'h37_00_18_00_4F});
        check_rng("snapshot_timing", bad, 0, 0);
        hum_int = 8'h37;
        repeat (5) @(negedge clk);

        // Reset during bit 20, then a fresh complete frame.
        host_start(1050, bm);
        r = 0; prev = 1'b0;
        for (int c = 0; c < 4000 && r < 21; c++) begin
            @(negedge clk);
            if (dht_oe && !prev) r++;
            prev = dht_oe;
        end
        check_rng("reach_bit20", r, 21, 21);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe",   {63'd0, dht_oe}, 64'd0);
        check("midrst_busy", {63'd0, busy},   64'd0);
        rst = 1'b0;
        fd0 = fd_cnt; oe0 = oe_cnt;
        repeat (200) @(negedge clk);
        check_rng("midrst_no_done", fd_cnt - fd0, 0, 0);
        check_rng("midrst_released", oe_cnt - oe0, 0, 0);
        host_start(1200, bm);
        capture(fr, bad);
        check("after_rst_frame", {24'd0, fr}, {24'd0, 40'h37_00_18_00_4F});
        check_rng("after_rst_timing", bad, 0, 0);
        repeat (5) @(negedge clk);

        // Host glitch during RESP_HIGH is ignored.
        fd0 = fd_cnt; se0 = se_cnt;
        host_start(1050, bm);
        fork
            capture(fr, bad);
            begin
                r = 0; prev = 1'b0;
                for (int c = 0; c < 500 && r < 1; c++) begin
                    @(negedge clk);
                    if (!dht_oe && prev) r++;
                    prev = dht_oe;
                end
                repeat (20) @(negedge clk);
                host_drive = 1'b1;
                repeat (30) @(negedge clk);
                host_drive = 1'b0;
            end
        join
        check("glitch_frame", {24'd0, fr}, {24'd0, 40'h37_00_18_00_4F});
        check_rng("glitch_timing", bad, 0, 0);
        repeat (5) @(negedge clk);
        check_rng("glitch_done", fd_cnt - fd0, 1, 1);
        check_rng("glitch_no_serr", se_cnt - se0, 0, 0);
        check("glitch_busy", {63'd0, busy}, 64'd0);
        host_start(1050, bm);
        capture(fr, bad);
        check("rearm_frame", {24'd0, fr}, {24'd0, 40'h37_00_18_00_4F});
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
